inc_dec_btn_ctrl: RTL
=====================

# inc_dec_btn_ctrl

Debounce and auto-repeat controller for the up/down buttons that adjust a PWM duty setting. It synchronises and debounces two raw button inputs, then emits single-cycle increment/decrement strobes with hold-to-repeat. It sits directly upstream of the inc/dec duty register: `INC_EN`, `DEC_EN` and `CE` connect straight to that register's matching inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to accept a button level change; must be ≥1.
- `REPEAT_DELAY`, default 25000000: cycles from the first strobe to the first repeat strobe; must be ≥2.
- `REPEAT_PERIOD`, default 5000000: cycles between subsequent repeat strobes; must be ≥2.
- `CLK` input 1: system clock; all logic on the rising edge.
- `CLR_N` input 1: reset, asynchronous, active-low.
- `BTN_UP` input 1: raw up button, active-high, asynchronous to `CLK`.
- `BTN_DOWN` input 1: raw down button, active-high, asynchronous to `CLK`.
- `INC_EN` output 1: one-cycle increment strobe, registered.
- `DEC_EN` output 1: one-cycle decrement strobe, registered.
- `CE` output 1: `INC_EN | DEC_EN`, registered alongside them.
- `UP_DB` output 1: debounced up level, for status LEDs.
- `DOWN_DB` output 1: debounced down level.

## Operation
- **Synchroniser.** Each button passes through a 2-FF synchroniser.
- **Debouncer (one per button).**
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - The counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments. When it reaches `DEBOUNCE_CYCLES`, the debounced level toggles and the counter clears.
- **FSM on debounced levels.**
  - IDLE:
    - exactly one button debounced high → FIRST;
    - both high → LOCK.
  - FIRST: emit one strobe for the pressed button.
    - → HOLD if auto-repeat is compiled in;
    - → WAIT_REL if it is not.
  - HOLD: count `REPEAT_DELAY`-1 cycles, then → REPEAT with a strobe.
  - REPEAT: emit a strobe every `REPEAT_PERIOD` cycles.
  - WAIT_REL: no strobes.
  - Exits common to FIRST, HOLD, REPEAT and WAIT_REL:
    - pressed button released → IDLE;
    - other button also pressed → LOCK.
  - LOCK: no strobes; → IDLE only when both debounced levels are low.
- **Strobe rules.**
  - `INC_EN` and `DEC_EN` are never high in the same cycle.
  - Each strobe is exactly 1 cycle wide.
- **Repeat counter.**
  - Width is `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)`.
  - Reloads on every strobe.
  - Saturates and never wraps.
- **Reset.** Assertion of `CLR_N` at any time, including mid-repeat, forces:
  - FSM to IDLE;
  - all counters to 0;
  - synchronisers and debounced levels to 0;
  - all outputs to 0 immediately.
  - After release, a button already held is treated as a new press. It strobes after the normal debounce latency.

## Timing
- **Reset values.** `INC_EN`, `DEC_EN`, `CE`, `UP_DB` and `DOWN_DB` are all 0.
- **Press latency.**
  - Raw input stable high from edge k → `UP_DB`/`DOWN_DB` high after edge k+2+`DEBOUNCE_CYCLES`.
  - Strobe high during the cycle after edge k+3+`DEBOUNCE_CYCLES`.
- **Glitches.** A glitch shorter than `DEBOUNCE_CYCLES` synced cycles produces no level change and no strobe.
- **Repeat timing.**
  - First strobe at cycle t.
  - First repeat at t+`REPEAT_DELAY`.
  - Further repeats at t+`REPEAT_DELAY`+n·`REPEAT_PERIOD`.
- **Release.** A debounced release in the same cycle a repeat would fire suppresses that strobe.
- **Simultaneous presses.** Both debounced levels rising in the same cycle → LOCK, no strobe.

## Configuration
- Macro: `INC_DEC_AUTO_REPEAT_EN`.
- Defined: HOLD/REPEAT states and the repeat counter are built. Holding a button produces repeated strobes.
- Undefined: the repeat counter and HOLD/REPEAT states are removed. FIRST → WAIT_REL, so exactly one strobe per press. `REPEAT_DELAY` and `REPEAT_PERIOD` are ignored.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8, macro defined unless stated.
1. Reset: hold `CLR_N`=0 with `BTN_UP`=1 → all outputs 0. Release at edge 0 → `UP_DB` high after edge 6, one `INC_EN`/`CE` pulse in the cycle after edge 7.
2. Bounce: toggle `BTN_UP` high for 3 cycles, low for 2, high for 3 → no strobe, `UP_DB` stays 0. Then hold high → exactly one `INC_EN` 7 cycles after the stable edge.
3. Auto-repeat: hold `BTN_DOWN` for 60 cycles after the first `DEC_EN` at t → `DEC_EN` pulses at t, t+20, t+28, t+36, t+44, t+52; `INC_EN` never high.
4. Simultaneous press: press both in the same cycle, then release `BTN_UP` only → no strobes while `BTN_DOWN` is held. Release both, then press `BTN_DOWN` → a single `DEC_EN` after 7 cycles.
5. Reset mid-repeat: pulse `CLR_N` low for 1 cycle during REPEAT with `BTN_UP` held → outputs 0 immediately. Next `INC_EN` comes 7 cycles after reset release, then the first repeat 20 cycles later.
6. Macro undefined: hold `BTN_UP` for 100 cycles → exactly one `INC_EN`. Release and re-press → exactly one more.

Source files
------------

// File: rtl/inc_dec_btn_ctrl.sv
// Up/down button debounce with single-cycle inc/dec strobes.
// Define INC_DEC_AUTO_REPEAT_EN to build hold-to-repeat (HOLD/REPEAT).
module inc_dec_btn_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic CLK,
  input  logic CLR_N,
  input  logic BTN_UP,
  input  logic BTN_DOWN,
  output logic INC_EN,
  output logic DEC_EN,
  output logic CE,
  output logic UP_DB,
  output logic DOWN_DB
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_rpt
    $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
  end

  logic [1:0] btn;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] db;

  assign btn = {BTN_DOWN, BTN_UP};

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Level flips only after the counter has sat at DB_MAX for a cycle.
  for (genvar g = 0; g < 2; g++) begin : g_db
    logic [DBW-1:0] cnt;
    logic           lvl;

    always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync2[g] == lvl) begin
        cnt <= '0;
      end else if (cnt == DB_MAX) begin
        cnt <= '0;
        lvl <= ~lvl;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign db[g] = lvl;
  end

  logic up_db;
  logic dn_db;

  assign up_db   = db[0];
  assign dn_db   = db[1];
  assign UP_DB   = up_db;
  assign DOWN_DB = dn_db;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
`ifdef INC_DEC_AUTO_REPEAT_EN
    S_HOLD,
    S_REPEAT,
`endif
    S_WAIT_REL,
    S_LOCK
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   dir_q;
  logic   dir_d;
  logic   fire;
  logic   inc_d;
  logic   dec_d;
  logic   pressed;
  logic   other;

  assign pressed = dir_q ? up_db : dn_db;
  assign other   = dir_q ? dn_db : up_db;

`ifdef INC_DEC_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DLY_LD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LD = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] cnt_q;
  logic [RW-1:0] cnt_d;
  logic [RW-1:0] cnt_dec;

  assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    fire    = 1'b0;
`ifdef INC_DEC_AUTO_REPEAT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (up_db && dn_db) begin
          state_d = S_LOCK;
        end else if (up_db ^ dn_db) begin
          state_d = S_FIRST;
          dir_d   = up_db;
          fire    = 1'b1;
`ifdef INC_DEC_AUTO_REPEAT_EN
          cnt_d   = DLY_LD;
`endif
        end
      end
      S_FIRST: begin
        if (!pressed) begin
          state_d = S_IDLE;
        end else if (other) begin
          state_d = S_LOCK;
        end else begin
`ifdef INC_DEC_AUTO_REPEAT_EN
          state_d = S_HOLD;
          cnt_d   = cnt_dec;
`else
          state_d = S_WAIT_REL;
`endif
        end
      end
`ifdef INC_DEC_AUTO_REPEAT_EN
      S_HOLD, S_REPEAT: begin
        // Release wins over a repeat due in the same cycle.
        if (!pressed) begin
          state_d = S_IDLE;
        end else if (other) begin
          state_d = S_LOCK;
        end else if (cnt_q == '0) begin
          state_d = S_REPEAT;
          fire    = 1'b1;
          cnt_d   = PER_LD;
        end else begin
          cnt_d   = cnt_dec;
        end
      end
`endif
      S_WAIT_REL: begin
        if (!pressed) begin
          state_d = S_IDLE;
        end else if (other) begin
          state_d = S_LOCK;
        end
      end
      S_LOCK: begin
        if (!up_db && !dn_db) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    inc_d = fire & dir_d;
    dec_d = fire & ~dir_d;
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      INC_EN  <= 1'b0;
      DEC_EN  <= 1'b0;
      CE      <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      INC_EN  <= inc_d;
      DEC_EN  <= dec_d;
      CE      <= inc_d | dec_d;
    end
  end

`ifdef INC_DEC_AUTO_REPEAT_EN
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule
